// File: rtl/stoplight_ctrl.sv
// stoplight_ctrl: two-way intersection light sequencer advanced by prescaler tick strobes.
// Latency: state, counter and lights all update on the clk edge that consumes a tick; lights are registered.
// Backpressure: none; tick is a strobe and ped_req is sampled every clk, nothing upstream is ever stalled.
//
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   tick         - single-cycle advance strobe from the prescaler
//   ped_req      - pedestrian request (level or pulse), latched into ped_pending
//   ns_light     - north-south {red, yellow, green}, one-hot
//   ew_light     - east-west {red, yellow, green}, one-hot
//   state        - current phase code (0 ALLRED_B, 1 NS_G, 2 NS_Y, 3 ALLRED_A, 4 EW_G, 5 EW_Y)
//   ped_pending  - latched pedestrian request
//   phase_done   - one-clk pulse on every phase transition
//   walk         - walk indicator
//
// Optional build macro: STOPLIGHT_WALK_EN adds the pedestrian walk extension
// to the all-red phase that follows a served request. Without it walk is 0.
module stoplight_ctrl #(
    parameter int GREEN_CYC  = 8,
    parameter int MIN_GREEN  = 3,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] state,
    output logic       ped_pending,
    output logic       phase_done,
    output logic       walk
);

    typedef enum logic [2:0] {
        ALLRED_B = 3'd0,
        NS_G     = 3'd1,
        NS_Y     = 3'd2,
        ALLRED_A = 3'd3,
        EW_G     = 3'd4,
        EW_Y     = 3'd5
    } phase_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Terminal counter values (duration - 1) for each phase class.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);

    phase_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    phase_t           nxt_state;
    phase_t           succ;
    logic [CNT_W-1:0] nxt_cnt;
    logic [CNT_W-1:0] phase_last;
    logic [CNT_W-1:0] allred_last;
    logic             is_green;
    logic             is_yellow;
    logic             legal;
    logic             leave;
    logic             enter_allred;
    logic             nxt_pend;
    logic [2:0]       nxt_ns;
    logic [2:0]       nxt_ew;

`ifdef STOPLIGHT_WALK_EN
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(ALLRED_CYC + WALK_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LIM   = CNT_W'(WALK_CYC);

    // serve_q marks an all-red phase that is giving pedestrians a walk interval.
    logic serve_q;
    logic nxt_serve;
    logic nxt_walk;

    assign allred_last = serve_q ? SERVE_LAST : ALLRED_LAST;
`else
    assign allred_last = ALLRED_LAST;
    assign walk        = 1'b0;
`endif

    assign state = state_q;

    // Phase table: terminal count and successor for the current phase.
    always_comb begin
        phase_last = '0;
        succ       = ALLRED_B;
        is_green   = 1'b0;
        is_yellow  = 1'b0;
        legal      = 1'b1;
        case (state_q)
            ALLRED_B: begin phase_last = allred_last; succ = NS_G;                       end
            NS_G:     begin phase_last = GREEN_LAST;  succ = NS_Y;     is_green  = 1'b1; end
            NS_Y:     begin phase_last = YELLOW_LAST; succ = ALLRED_A; is_yellow = 1'b1; end
            ALLRED_A: begin phase_last = allred_last; succ = EW_G;                       end
            EW_G:     begin phase_last = GREEN_LAST;  succ = EW_Y;     is_green  = 1'b1; end
            EW_Y:     begin phase_last = YELLOW_LAST; succ = ALLRED_B; is_yellow = 1'b1; end
            default:  legal = 1'b0;
        endcase
    end

    // Next-state logic. An illegal code recovers to ALLRED_B without waiting
    // for a tick; a pending pedestrian cuts green short once the minimum is met.
    always_comb begin
        leave = !legal ||
                (tick && ((cnt_q == phase_last) ||
                          (is_green && ped_pending && (cnt_q >= MIN_LAST))));

        nxt_state = leave ? succ : state_q;

        if (leave) begin
            nxt_cnt = '0;
        end else if (tick) begin
            nxt_cnt = cnt_q + 1'b1;
        end else begin
            nxt_cnt = cnt_q;
        end

        enter_allred = leave && ((succ == ALLRED_A) || (succ == ALLRED_B));

        // A new request on the clearing edge wins over the clear.
        nxt_pend = ped_req | (ped_pending & ~enter_allred);

`ifdef STOPLIGHT_WALK_EN
        // Serve is decided from the request state before this edge's clear.
        nxt_serve = leave ? (enter_allred && is_yellow && ped_pending) : serve_q;
        nxt_walk  = nxt_serve && (nxt_cnt < WALK_LIM);
`endif
    end

    // Light decode of the next state so the registered lights line up with state.
    always_comb begin
        nxt_ns = LIGHT_RED;
        nxt_ew = LIGHT_RED;
        case (nxt_state)
            NS_G:    nxt_ns = LIGHT_GREEN;
            NS_Y:    nxt_ns = LIGHT_YELLOW;
            EW_G:    nxt_ew = LIGHT_GREEN;
            EW_Y:    nxt_ew = LIGHT_YELLOW;
            default: begin
                nxt_ns = LIGHT_RED;
                nxt_ew = LIGHT_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ALLRED_B;
            cnt_q       <= '0;
            ns_light    <= LIGHT_RED;
            ew_light    <= LIGHT_RED;
            ped_pending <= 1'b0;
            phase_done  <= 1'b0;
`ifdef STOPLIGHT_WALK_EN
            serve_q     <= 1'b0;
            walk        <= 1'b0;
`endif
        end else begin
            state_q     <= nxt_state;
            cnt_q       <= nxt_cnt;
            ns_light    <= nxt_ns;
            ew_light    <= nxt_ew;
            ped_pending <= nxt_pend;
            phase_done  <= leave && legal;
`ifdef STOPLIGHT_WALK_EN
            serve_q     <= nxt_serve;
            walk        <= nxt_walk;
`endif
        end
    end

endmodule

// File: tb/tb_stoplight_ctrl.sv
// tb_stoplight_ctrl: self-checking bench for stoplight_ctrl.
// Latency: compares outputs 1 time unit after each rising edge against a phase/elapsed-tick model.
// Backpressure: none; the bench drives tick and ped_req freely.
module tb_stoplight_ctrl;

    localparam int GREEN_CYC  = 8;
    localparam int MIN_GREEN  = 3;
    localparam int YELLOW_CYC = 2;
    localparam int ALLRED_CYC = 1;
    localparam int WALK_CYC   = 4;
    localparam int CNT_W      = 4;
`ifdef STOPLIGHT_WALK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] state;
    logic       ped_pending;
    logic       phase_done;
    logic       walk;

    always #5 tb_clk = ~tb_clk;

    stoplight_ctrl #(
        .GREEN_CYC (GREEN_CYC),
        .MIN_GREEN (MIN_GREEN),
        .YELLOW_CYC(YELLOW_CYC),
        .ALLRED_CYC(ALLRED_CYC),
        .WALK_CYC  (WALK_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .tick       (tick),
        .ped_req    (ped_req),
        .ns_light   (ns_light),
        .ew_light   (ew_light),
        .state      (state),
        .ped_pending(ped_pending),
        .phase_done (phase_done),
        .walk       (walk)
    );

    logic [11:0] dut_vec;
    assign dut_vec = {state, ns_light, ew_light, ped_pending, phase_done, walk};

    localparam logic [11:0] RESET_VEC = 12'b000_100_100_000;

    int checks = 0;
    int passes = 0;

    // Reference model: which phase we are in (0..5 in sequence order) and how
    // many ticks have been spent in it.
    int m_phase   = 0;
    int m_elapsed = 0;
    bit m_pend    = 1'b0;
    bit m_serve   = 1'b0;
    bit m_done    = 1'b0;
    bit m_walk    = 1'b0;

    function automatic bit is_green(input int p);
        return (p == 1) || (p == 4);
    endfunction

    function automatic int dur_of(input int p, input bit serve);
        case (p)
            1, 4:    return GREEN_CYC;
            2, 5:    return YELLOW_CYC;
            default: return ALLRED_CYC + (serve ? WALK_CYC : 0);
        endcase
    endfunction

    task automatic model_step(input bit r, input bit t, input bit q);
        bit leave;
        bit enter_ar;
        int np;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_pend = 0; m_serve = 0; m_done = 0; m_walk = 0;
            return;
        end
        leave    = 1'b0;
        enter_ar = 1'b0;
        np       = (m_phase + 1) % 6;
        if (t) begin
            if (is_green(m_phase) && m_pend && (m_elapsed >= MIN_GREEN - 1)) leave = 1'b1;
            else if (m_elapsed + 1 >= dur_of(m_phase, m_serve))                 leave = 1'b1;
        end
        m_done = leave;
        if (leave) begin
            enter_ar  = (np == 0) || (np == 3);
            m_serve   = WALK_EN && enter_ar && m_pend;
            m_phase   = np;
            m_elapsed = 0;
        end else if (t) begin
            m_elapsed++;
        end
        m_pend = q || (m_pend && !enter_ar);
        m_walk = m_serve && (m_elapsed < WALK_CYC);
    endtask

    function automatic logic [11:0] exp_vec();
        logic [2:0] ns;
        logic [2:0] ew;
        ns = 3'b100;
        ew = 3'b100;
        case (m_phase)
            1: ns = 3'b001;
            2: ns = 3'b010;
            4: ew = 3'b001;
            5: ew = 3'b010;
            default: ;
        endcase
        return {3'(m_phase), ns, ew, m_pend, m_done, m_walk};
    endfunction

    // One clock: drive inputs, wait for the edge, step the model, settle.
    task automatic cycle(input bit r, input bit t, input bit q);
        rst = r; tick = t; ped_req = q;
        @(posedge tb_clk);
        model_step(r, t, q);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        checks++;
        if (dut_vec !== RESET_VEC) $display("FAIL reset_values dut=%b expected=%b", dut_vec, RESET_VEC);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0);
            checks++;
            if (dut_vec !== RESET_VEC) $display("FAIL reset_hold cyc %0d dut=%b expected=%b", i, dut_vec, RESET_VEC);
            else passes++;
        end
    endtask

    task automatic test_free_run();
        int ev_k [8] = '{1, 8, 9, 11, 12, 20, 22, 23};
        logic [2:0] ev_s [8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        int done_cnt = 0;
        for (int k = 1; k <= 44; k++) begin
            cycle(0, 1, 0);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL free_run_model edge %0d dut=%b expected=%b", k, dut_vec, exp_vec());
            else passes++;
            checks++;
            if (ns_light !== 3'b100 && ew_light !== 3'b100) $display("FAIL free_run_safety edge %0d ns=%b ew=%b", k, ns_light, ew_light);
            else passes++;
            for (int j = 0; j < 8; j++) begin
                if (ev_k[j] == k) begin
                    checks++;
                    if (state !== ev_s[j]) $display("FAIL free_run_timeline edge %0d state=%0d expected=%0d", k, state, ev_s[j]);
                    else passes++;
                end
            end
            if (k <= 22 && phase_done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 6) $display("FAIL free_run_done_count got=%0d expected=6", done_cnt);
        else passes++;
    endtask

    task automatic test_ped_early();
        int n = 0;
        int edges;
        while (!(m_phase == 1 && m_elapsed == 0) && n < 100) begin
            cycle(0, 1, 0); n++;
        end
        checks++;
        if (n >= 100) $display("FAIL ped_early_reach_nsg timeout state=%0d", state);
        else passes++;
        cycle(0, 1, 1);
        edges = 1;
        checks++;
        if (ped_pending !== 1'b1 || dut_vec !== exp_vec()) $display("FAIL ped_early_latch dut=%b expected=%b", dut_vec, exp_vec());
        else passes++;
        while (state !== 3'd2 && edges < 20) begin
            cycle(0, 1, 0); edges++;
        end
        checks++;
        if (edges != 3) $display("FAIL ped_early_green_len ticks=%0d expected=3", edges);
        else passes++;
        n = 0;
        while (state !== 3'd3 && n < 20) begin
            cycle(0, 1, 0); n++;
        end
        checks++;
        if (n >= 20 || ped_pending !== 1'b0 || dut_vec !== exp_vec())
            $display("FAIL ped_early_clear state=%0d pending=%b expected state=3 pending=0", state, ped_pending);
        else passes++;
    endtask

    task automatic test_ped_late();
        int n = 0;
        while (!(m_phase == 1 && m_elapsed == 5 && !m_pend) && n < 200) begin
            cycle(0, 1, 0); n++;
        end
        checks++;
        if (n >= 200) $display("FAIL ped_late_reach timeout state=%0d", state);
        else passes++;
        cycle(0, 1, 1);
        checks++;
        if (state !== 3'd1 || ped_pending !== 1'b1) $display("FAIL ped_late_latch state=%0d pending=%b expected state=1 pending=1", state, ped_pending);
        else passes++;
        cycle(0, 1, 0);
        checks++;
        if (state !== 3'd2 || dut_vec !== exp_vec()) $display("FAIL ped_late_exit state=%0d expected=2", state);
        else passes++;
        // Request on the very edge that enters ALLRED_A, arriving with nothing pending.
        n = 0;
        while (!(m_phase == 2 && m_elapsed == YELLOW_CYC - 1 && !m_pend) && n < 200) begin
            cycle(0, 1, 0); n++;
        end
        checks++;
        if (n >= 200) $display("FAIL ped_late_reach_yellow timeout state=%0d", state);
        else passes++;
        cycle(0, 1, 1);
        checks++;
        if (state !== 3'd3 || ped_pending !== 1'b1) $display("FAIL set_wins_clear state=%0d pending=%b expected state=3 pending=1", state, ped_pending);
        else passes++;
    endtask

    task automatic test_slow_tick();
        int done_cnt = 0;
        int n = 0;
        for (int i = 0; i < 188; i++) begin
            cycle(0, (i % 4) == 3, 0);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL slow_tick_model cyc %0d dut=%b expected=%b", i, dut_vec, exp_vec());
            else passes++;
            if (i >= 100 && phase_done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 6) $display("FAIL slow_tick_done_count got=%0d expected=6", done_cnt);
        else passes++;
        while (!(m_phase == 4 && m_elapsed == 2) && n < 300) begin
            cycle(0, (n % 4) == 3, 0); n++;
        end
        checks++;
        if (n >= 300) $display("FAIL slow_tick_reach_ewg timeout state=%0d", state);
        else passes++;
        cycle(1, 0, 0);
        checks++;
        if (dut_vec !== RESET_VEC) $display("FAIL mid_phase_reset dut=%b expected=%b", dut_vec, RESET_VEC);
        else passes++;
    endtask

    task automatic test_random();
        bit r, t, q;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) == 0);
            t = ($urandom_range(0, 2) != 0);
            q = ($urandom_range(0, 11) == 0);
            cycle(r, t, q);
            checks++;
            if (dut_vec !== exp_vec()) $display("FAIL random_model cyc %0d dut=%b expected=%b", i, dut_vec, exp_vec());
            else passes++;
            checks++;
            if (ns_light !== 3'b100 && ew_light !== 3'b100) $display("FAIL random_safety cyc %0d ns=%b ew=%b", i, ns_light, ew_light);
            else passes++;
        end
    endtask

    // Counts ALLRED_B length (ticks) and walk cycles, with tick every clk.
    task automatic measure_allred_b(output int len, output int walk_n, output bit ok);
        int n = 0;
        len = 0; walk_n = 0;
        while (state !== 3'd0 && n < 100) begin
            cycle(0, 1, 0); n++;
        end
        while (state === 3'd0 && len < 20) begin
            if (walk === 1'b1) walk_n++;
            cycle(0, 1, 0); len++;
        end
        ok = (n < 100) && (len < 20);
    endtask

    task automatic test_walk();
        int n = 0;
        int len, walk_n;
        bit ok;
        cycle(1, 0, 0);
        while (m_phase != 4 && n < 100) begin
            cycle(0, 1, 0); n++;
        end
        cycle(0, 1, 1);
        measure_allred_b(len, walk_n, ok);
        checks++;
        if (!ok || len != (WALK_EN ? 5 : 1) || walk_n != (WALK_EN ? 4 : 0))
            $display("FAIL walk_served len=%0d walk=%0d expected len=%0d walk=%0d", len, walk_n, WALK_EN ? 5 : 1, WALK_EN ? 4 : 0);
        else passes++;
        measure_allred_b(len, walk_n, ok);
        checks++;
        if (!ok || len != 1 || walk_n != 0)
            $display("FAIL walk_unserved len=%0d walk=%0d expected len=1 walk=0", len, walk_n);
        else passes++;
        checks++;
        if (dut_vec !== exp_vec()) $display("FAIL walk_model dut=%b expected=%b", dut_vec, exp_vec());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ped_early();
        test_ped_late();
        test_slow_tick();
        test_random();
        test_walk();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
